// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: FSM states,
// stop-bit encodings and the bit-time clamp.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  localparam logic [1:0]  STOP_1           = 2'b01;
  localparam logic [1:0]  STOP_2           = 2'b10;
  localparam logic [15:0] MIN_BIT_DURATION = 16'd4;

  // Below 4 cycles/bit the half-bit offset collapses and mid-bit sampling is lost.
  function automatic logic [15:0] clamp_bit_duration(input logic [15:0] bd);
    return (bd < MIN_BIT_DURATION) ? MIN_BIT_DURATION : bd;
  endfunction

  // 2'b10 and 2'b11 select two stop bits; 2'b00 and 2'b01 select one.
  function automatic logic is_two_stop(input logic [1:0] sb);
    return sb[1];
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous level input; resets to 1 so an
// idle-high line does not glitch low when reset releases.
module uart_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1/8N2 UART receiver: mid-bit sampling from a single
// down-counter, one-cycle data_valid strobe with a sticky framing-error flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] bit_duration,
  input  logic [1:0]  stopbits,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        frame_error,
  output logic        busy,
  output uart_state_e dbg_state
);

  logic rx_s;

  uart_sync #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rx_s)
  );

  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] bd_q, bd_d;
  logic [2:0]  idx_q, idx_d;
  logic        two_stop_q, two_stop_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        err_q, err_d;
  logic        rx_prev_q, rx_prev_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_error_q, frame_error_d;
  logic        busy_q, busy_d;

  logic [15:0] bd_clamped;
  logic        tick;

  assign bd_clamped = clamp_bit_duration(bit_duration);
  assign tick       = (cnt_q == 16'd0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bd_d          = bd_q;
    idx_d         = idx_q;
    two_stop_d    = two_stop_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    err_d         = err_q;
    rx_prev_d     = rx_s;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    frame_error_d = frame_error_q;

    case (state_q)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a held break does not retrigger.
        if (rx_prev_q && !rx_s) begin
          bd_d       = bd_clamped;
          cnt_d      = (bd_clamped >> 1) - 16'd1;
          two_stop_d = is_two_stop(stopbits);
          err_d      = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = bd_q - 16'd1;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = bd_q - 16'd1;
          if (idx_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
          err_d = err_q | ~rx_s;
          cnt_d = bd_q - 16'd1;
          if (stop_cnt_q == two_stop_q) begin
            state_d = DONE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DONE: begin
        data_d        = shift_q;
        frame_error_d = err_q;
        data_valid_d  = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy stays up through the strobe cycle and drops with it.
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      bd_q          <= MIN_BIT_DURATION;
      idx_q         <= 3'd0;
      two_stop_q    <= 1'b0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= 8'h00;
      err_q         <= 1'b0;
      rx_prev_q     <= 1'b1;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bd_q          <= bd_d;
      idx_q         <= idx_d;
      two_stop_q    <= two_stop_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      err_q         <= err_d;
      rx_prev_q     <= rx_prev_d;
      data_q        <= data_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule
